// File: rtl/lifo_arbiter.sv
// Two-requester round-robin front end for a single-ported synchronous LIFO stack.
// Define LIFO_ARB_FIXED_PRIO_EN to make requester 0 always win ties instead.
module lifo_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req0_push,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    output logic             req0_rvalid,
    output logic [WIDTH-1:0] req0_rdata,
    output logic             req0_err,
    input  logic             req1_valid,
    input  logic             req1_push,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             req1_rvalid,
    output logic [WIDTH-1:0] req1_rdata,
    output logic             req1_err,
    output logic             stk_en,
    output logic             stk_push,
    output logic [WIDTH-1:0] stk_wdata,
    input  logic [WIDTH-1:0] stk_rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic             gnt0, gnt1, accept;
    logic             sel_push, acc_err;
    logic [WIDTH-1:0] sel_data;
    logic             lat_id, lat_op, lat_err;
    logic [WIDTH-1:0] lat_data, resp_data;
    logic             pop_ok;

`ifdef LIFO_ARB_FIXED_PRIO_EN
    assign gnt0 = req0_valid;
    assign gnt1 = req1_valid & ~req0_valid;
`else
    // last holds the most recently granted requester; the other one wins a tie
    logic last;

    assign gnt0 = req0_valid & (~req1_valid | last);
    assign gnt1 = req1_valid & (~req0_valid | ~last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 1'b1;
        else if (accept)
            last <= gnt1;
    end
`endif

    assign req0_ready = (state == IDLE) & gnt0;
    assign req1_ready = (state == IDLE) & gnt1;
    assign accept     = req0_ready | req1_ready;

    assign sel_push = gnt1 ? req1_push : req0_push;
    assign sel_data = gnt1 ? req1_data : req0_data;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // Overflow/underflow judged on the occupancy seen at acceptance
    assign acc_err  = sel_push ? full : empty;
    assign pop_ok   = ~lat_op & ~lat_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lat_id   <= 1'b0;
            lat_op   <= 1'b0;
            lat_err  <= 1'b0;
            lat_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_id   <= gnt1;
                lat_op   <= sel_push;
                lat_err  <= acc_err;
                lat_data <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            resp_data <= '0;
        end else begin
            if (state == ISSUE && !lat_err)
                count <= lat_op ? count + CNT_W'(1) : count - CNT_W'(1);
            if (state == WAIT)
                resp_data <= stk_rdata;
        end
    end

    always_comb begin
        state_nxt   = state;
        stk_en      = 1'b0;
        stk_push    = 1'b0;
        stk_wdata   = '0;
        req0_rvalid = 1'b0;
        req1_rvalid = 1'b0;
        req0_rdata  = '0;
        req1_rdata  = '0;
        req0_err    = 1'b0;
        req1_err    = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                stk_en    = ~lat_err;
                stk_push  = lat_op;
                stk_wdata = lat_data;
                state_nxt = pop_ok ? WAIT : RESP;
            end
            WAIT: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (lat_id) begin
                    req1_rvalid = 1'b1;
                    req1_rdata  = pop_ok ? resp_data : '0;
                    req1_err    = lat_err;
                end else begin
                    req0_rvalid = 1'b1;
                    req0_rdata  = pop_ok ? resp_data : '0;
                    req0_err    = lat_err;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
- Sequences a single-ported synchronous LIFO stack and shares it between two requesters.
- Arbitrates push/pop requests round-robin and issues one stack operation at a time.
- Owns the occupancy count and rejects overflow and underflow without touching the stack.
- Returns pop data or an error status to the requester that issued the operation.

Parameters:
- WIDTH, 8: data width of requests, responses and the stack port.
- DEPTH, 12: stack capacity in entries.
- CNT_W, 4: width of the occupancy counter; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_push  in  1  requester 0 operation: 1=push, 0=pop.
- req0_data  in  WIDTH  requester 0 push data.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_rvalid  out  1  one-cycle pulse: requester 0 response valid.
- req0_rdata  out  WIDTH  pop data for requester 0; 0 for a push or an error.
- req0_err  out  1  qualified by req0_rvalid; 1 = overflow or underflow.
- req1_valid, req1_push, req1_data, req1_ready, req1_rvalid, req1_rdata, req1_err: same as requester 0, for requester 1.
- stk_en  out  1  stack operation strobe, one cycle.
- stk_push  out  1  stack operation: 1=push, 0=pop.
- stk_wdata  out  WIDTH  stack push data.
- stk_rdata  in  WIDTH  stack pop data; valid the cycle after a pop strobe.
- count  out  CNT_W  current occupancy.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

Behaviour:
- Reset: asynchronous on rst_n low.
  - FSM goes to IDLE, count=0 and the round-robin pointer last=1, so requester 0 is favoured first.
  - Every output is 0 except empty, which is 1.
  - Any in-flight transaction is dropped with no response.
  - Stack contents are unreachable after reset because count is 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one valid is high, grant that requester.
  - If both are high, grant the requester that is not `last`.
  - reqN_ready is combinational and high only for the granted requester, only in IDLE.
  - On acceptance (valid & ready), latch id, op, data and err, then go to ISSUE and set last=id.
  - err = (push & full) | (pop & empty), evaluated on the count at acceptance.
- ISSUE, one cycle:
  - stk_en = ~err, stk_push = op and stk_wdata = the latched data.
  - On a successful push, count+1; on a successful pop, count-1; no change on an error.
  - Next state is WAIT for a successful pop, otherwise RESP.
- WAIT, one cycle: capture stk_rdata into the response register, then go to RESP.
- RESP, one cycle:
  - Pulse reqN_rvalid for the latched id.
  - reqN_rdata is the captured data for a successful pop, otherwise 0.
  - reqN_err = err.
  - Next state is IDLE.
- Requesters hold valid, push and data stable until ready. Valid may drop only after acceptance.
- Latency from the acceptance cycle T:
  - push or error: rvalid at T+2;
  - pop: rvalid at T+3.
  - Next acceptance is at T+3 (push or error) or T+4 (pop).
- Outputs outside their defined cycles:
  - stk_en, stk_push, stk_wdata, rvalid, rdata and err are 0.
  - full and empty are combinational from count.
- Boundaries:
  - A push at count==DEPTH is an error; count stays at DEPTH and the stack is not strobed.
  - A pop at count==0 is an error; count stays at 0.
  - count never wraps.
- Valid high on a non-granted requester is ignored; that requester's ready stays 0.
- Reset asserted mid-transaction: no rvalid is emitted and stk_en drops immediately.

Optional Feature:
- Macro LIFO_ARB_FIXED_PRIO_EN.
  - Defined: fixed priority, requester 0 always wins when both are valid. The last pointer is not implemented.
  - Undefined: round-robin as described in Behaviour.

Test Plan:
- After reset: req0 push 0xA5 -> req0_ready at T, stk_en=1/stk_push=1/stk_wdata=0xA5 at T+1, count=1, req0_rvalid=1 with err=0 at T+2.
- After the push above, req1 pops -> stk_en=1/stk_push=0 at T+1, stk_rdata=0xA5 at T+2, req1_rvalid=1 with rdata=0xA5, err=0 at T+3; count=0 and empty=1.
- Pop at count=0 -> no stk_en, req0_rvalid=1, err=1, rdata=0, count stays 0.
- 12 pushes of 0x01..0x0C, then a 13th push -> full=1 after the 12th; the 13th returns err=1 with no stk_en and count=12.
- 12 pops after the fill -> rdata order 0x0C..0x01, then empty=1.
- Both requesters hold valid pushing, 4 operations -> grants alternate 0,1,0,1.
  - With LIFO_ARB_FIXED_PRIO_EN defined, all 4 grants go to requester 0.
- rst_n pulled low during WAIT of a pop -> no rvalid, count=0, all outputs 0 except empty=1; the next request is serviced normally.
